uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of uart_rx. Captures each received byte plus its parity-error tag on a one-cycle write strobe and holds them in a circular FIFO. Presents bytes to the register/bus side through a registered pop interface, with level, overrun and threshold status. Single clock domain, same clk as uart_rx.

Parameters:
DEPTH, 16, number of entries; power of two, 2..256
AW, 4, pointer width = log2(DEPTH)
TOUT_CYC, 640, idle cycles before timeout interrupt (optional feature only; ~4 char times at 16x oversample)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_en  in  1  receiver enable; 0 flushes FIFO
wr_vld  in  1  one-cycle strobe: byte received (from uart_rx rx_ok)
wr_data  in  8  received byte (uart_rx rxd_out)
wr_perr  in  1  parity error tag for this byte
rd_req  in  1  pop request from bus side
rd_data  out  8  popped byte, registered
rd_perr  out  1  parity tag of popped byte, registered
rd_vld  out  1  1-cycle pulse: rd_data/rd_perr updated
empty  out  1  count == 0
full  out  1  count == DEPTH
count  out  AW+1  current occupancy
thresh  in  AW+1  interrupt level
irq_lvl  out  1  count >= thresh and thresh != 0
overrun  out  1  sticky: write dropped because full
ovr_clr  in  1  clears overrun
irq_tout  out  1  timeout interrupt (0 when feature compiled out)

Behaviour:
- Synchronous active-high reset; reset sets: wr_ptr=0, rd_ptr=0, count=0, rd_data=8'hFF, rd_perr=0, rd_vld=0, overrun=0, irq_tout=0. Hence empty=1, full=0, irq_lvl=0.
- Storage: DEPTH x 9-bit array {perr,data}; not reset; pointers AW bits, wrap DEPTH-1 -> 0 naturally.
- Write: wr_vld=1 and not full -> store at wr_ptr, wr_ptr+1, count+1.
- Write when full: data discarded, pointers unchanged, overrun <= 1.
- Read: rd_req=1 and not empty -> next cycle rd_data/rd_perr = entry at rd_ptr, rd_vld=1 for one cycle; rd_ptr+1, count-1. Latency 1 cycle.
- Read when empty: ignored; rd_vld=0, rd_data/rd_perr hold.
- Simultaneous write and read, not empty and not full: both occur, count unchanged.
- Simultaneous write and read when empty: read ignored, write accepted (count 0->1); no fall-through.
- Simultaneous write and read when full: read accepted, write is dropped (full evaluated on current-cycle count), overrun <= 1.
- overrun: sticky; ovr_clr=1 clears it; if ovr_clr and a dropping write occur in the same cycle, set wins.
- rx_en=0: synchronous flush (pointers/count to 0, overrun cleared, timeout counter cleared); rd_data holds last value; writes and reads ignored while low.
- irq_lvl combinational from count and thresh; thresh > DEPTH never asserts.
- Status outputs (empty, full, count) reflect registered count; update the cycle after the push/pop.

Optional Feature:
Macro UART_RX_FIFO_TIMEOUT_EN.
- Defined: 16-bit idle counter cleared by reset, flush, any accepted write or accepted read, and when empty; otherwise increments while count != 0, saturating. When counter == TOUT_CYC-1, irq_tout <= 1 (sticky); irq_tout clears on next accepted read or on flush.
- Not defined: no counter logic; irq_tout tied to 0.

Test Plan:
- Reset then 3 writes 0x41,0x42,0x43 (perr 0,1,0) -> count=3; 3 pops give rd_data 0x41/0x42/0x43 with rd_perr 0/1/0, each 1 cycle after rd_req; then empty=1.
- Write 17 bytes 0x00..0x10 with DEPTH=16 -> full=1 after 16th, 0x10 dropped, overrun=1; 16 pops return 0x00..0x0F; ovr_clr -> overrun=0.
- Fill to 16, then simultaneous wr_vld(0xAA)+rd_req -> pop returns first byte, 0xAA dropped, overrun=1, count=15; at count=8, simultaneous push/pop -> count stays 8.
- thresh=4: 3 writes -> irq_lvl=0; 4th -> irq_lvl=1; one pop -> 0; thresh=0 -> irq_lvl never asserts.
- 20 push/pop pairs across wrap boundary -> data order preserved; pop on empty -> rd_vld=0, rd_data holds; rx_en low with count=5 -> count=0 next cycle.
- With UART_RX_FIFO_TIMEOUT_EN, TOUT_CYC=640: one write, idle -> irq_tout=1 exactly 640 cycles after write; pop clears it; without macro irq_tout stays 0.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Bus-side bundle for uart_rx_fifo: uart_rx write strobe, register-side pop
// port, and status/interrupt lines. The master drives stimulus; the FIFO is the slave.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
);
  logic          rx_en;
  logic          wr_vld;
  logic [7:0]    wr_data;
  logic          wr_perr;
  logic          rd_req;
  logic [7:0]    rd_data;
  logic          rd_perr;
  logic          rd_vld;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic [AW:0]   thresh;
  logic          irq_lvl;
  logic          overrun;
  logic          ovr_clr;
  logic          irq_tout;

  modport master (
    output rx_en, wr_vld, wr_data, wr_perr, rd_req, thresh, ovr_clr,
    input  rd_data, rd_perr, rd_vld, empty, full, count, irq_lvl, overrun, irq_tout
  );

  modport slave (
    input  rx_en, wr_vld, wr_data, wr_perr, rd_req, thresh, ovr_clr,
    output rd_data, rd_perr, rd_vld, empty, full, count, irq_lvl, overrun, irq_tout
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind uart_rx: {perr,data} circular buffer with a registered pop
// port, level/overrun status. Idle timeout irq is enabled by UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int TOUT_CYC = 640
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  if (DEPTH != (1 << AW) || DEPTH < 2 || DEPTH > 256 || TOUT_CYC < 2 || TOUT_CYC > 65536)
  begin : g_bad_cfg
    $error("uart_rx_fifo: inconsistent DEPTH/AW/TOUT_CYC");
  end

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          is_empty, is_full;
  logic          wr_acc, rd_acc, wr_drop;
  logic [7:0]    rd_data_q;
  logic          rd_perr_q, rd_vld_q, ovr_q;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == DEPTH_C);

  // Full/empty come from the registered count, so a write and a read in the
  // same cycle on a full FIFO still drop the write; no fall-through when empty.
  assign wr_acc  = bus.rx_en && bus.wr_vld && !is_full;
  assign wr_drop = bus.rx_en && bus.wr_vld &&  is_full;
  assign rd_acc  = bus.rx_en && bus.rd_req && !is_empty;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= {bus.wr_perr, bus.wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      rd_data_q <= 8'hFF;
      rd_perr_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      ovr_q     <= 1'b0;
    end else if (!bus.rx_en) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      rd_vld_q  <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rd_vld_q <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr                 <= rd_ptr + 1'b1;
        {rd_perr_q, rd_data_q} <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (wr_drop)          ovr_q <= 1'b1;
      else if (bus.ovr_clr) ovr_q <= 1'b0;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.rd_perr = rd_perr_q;
  assign bus.rd_vld  = rd_vld_q;
  assign bus.empty   = is_empty;
  assign bus.full    = is_full;
  assign bus.count   = cnt;
  assign bus.overrun = ovr_q;
  // thresh above DEPTH can never be reached by cnt, so it never fires
  assign bus.irq_lvl = (bus.thresh != '0) && (cnt >= bus.thresh);

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] tout_cnt;
  logic        tout_q;

  always_ff @(posedge clk) begin
    if (rst || !bus.rx_en) begin
      tout_cnt <= '0;
      tout_q   <= 1'b0;
    end else begin
      if (wr_acc || rd_acc || is_empty) tout_cnt <= '0;
      else if (tout_cnt != 16'hFFFF)    tout_cnt <= tout_cnt + 1'b1;
      if (rd_acc)                                 tout_q <= 1'b0;
      else if (tout_cnt == 16'(TOUT_CYC - 1))     tout_q <= 1'b1;
    end
  end

  assign bus.irq_tout = tout_q;
`else
  assign bus.irq_tout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected {perr,data} queued on push,
// popped and compared whenever rd_vld is seen; status checked against a model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk, rst;
  uart_rx_fifo_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .TOUT_CYC(640)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] q[$];
  int         mcount  = 0;
  logic       mov     = 1'b0;
  int         mthr    = 0;
  logic       mtout   = 1'b0;
  logic [7:0] last_rd = 8'hFF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status();
    chk("count",    32'(bus.count),   32'(mcount));
    chk("empty",    32'(bus.empty),   32'(mcount == 0));
    chk("full",     32'(bus.full),    32'(mcount == DEPTH));
    chk("overrun",  32'(bus.overrun), 32'(mov));
    chk("irq_lvl",  32'(bus.irq_lvl), 32'(mthr != 0 && mcount >= mthr));
    chk("irq_tout", 32'(bus.irq_tout), 32'(mtout));
  endtask

  task automatic push(input logic [7:0] d, input logic p);
    bus.wr_vld = 1'b1; bus.wr_data = d; bus.wr_perr = p;
    if (mcount < DEPTH) begin q.push_back({p, d}); mcount++; end
    else mov = 1'b1;
    step();
    bus.wr_vld = 1'b0;
    check_status();
  endtask

  task automatic pop();
    logic acc;
    acc = (mcount > 0);
    if (acc) mcount--;
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    chk("rd_vld", 32'(bus.rd_vld), 32'(acc));
    if (!acc) chk("rd_hold", 32'(bus.rd_data), 32'(last_rd));
    if (acc) mtout = 1'b0;
    check_status();
  endtask

  task automatic pushpop(input logic [7:0] d, input logic p);
    logic wa, ra;
    wa = (mcount < DEPTH);
    ra = (mcount > 0);
    if (wa) q.push_back({p, d}); else mov = 1'b1;
    mcount = mcount + int'(wa) - int'(ra);
    bus.wr_vld = 1'b1; bus.wr_data = d; bus.wr_perr = p; bus.rd_req = 1'b1;
    step();
    bus.wr_vld = 1'b0; bus.rd_req = 1'b0;
    chk("pp_rd_vld", 32'(bus.rd_vld), 32'(ra));
    check_status();
  endtask

  task automatic clr_ovr();
    bus.ovr_clr = 1'b1;
    step();
    bus.ovr_clr = 1'b0;
    mov = 1'b0;
    check_status();
  endtask

  task automatic drain();
    while (mcount > 0) pop();
  endtask

  // Every rd_vld pulse must match the oldest outstanding byte
  always @(negedge clk) begin
    if (!rst && bus.rd_vld) begin
      if (q.size() == 0) chk("rd_spurious", 32'd1, 32'd0);
      else begin
        logic [8:0] e;
        e = q.pop_front();
        chk("rd_data", 32'(bus.rd_data), 32'(e[7:0]));
        chk("rd_perr", 32'(bus.rd_perr), 32'(e[8]));
      end
      last_rd = bus.rd_data;
    end
  end

  initial begin
    rst = 1'b1;
    bus.rx_en = 1'b1; bus.wr_vld = 1'b0; bus.wr_data = '0; bus.wr_perr = 1'b0;
    bus.rd_req = 1'b0; bus.thresh = '0; bus.ovr_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_rd_data", 32'(bus.rd_data), 32'hFF);
    chk("rst_rd_perr", 32'(bus.rd_perr), 32'd0);
    chk("rst_rd_vld",  32'(bus.rd_vld),  32'd0);
    check_status();

    // basic push/pop with parity tags
    push(8'h41, 1'b0); push(8'h42, 1'b1); push(8'h43, 1'b0);
    chk("cnt3", 32'(bus.count), 32'd3);
    pop(); pop(); pop();
    chk("empty_after3", 32'(bus.empty), 32'd1);

    // overflow: 17 writes, 17th dropped
    for (int i = 0; i < 17; i++) push(8'(i), 1'(i & 1));
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    drain();
    clr_ovr();

    // full + simultaneous push/pop drops the write
    for (int i = 0; i < DEPTH; i++) push(8'h60 + 8'(i), 1'b0);
    pushpop(8'hAA, 1'b1);
    chk("pp_full_cnt", 32'(bus.count), 32'd15);
    for (int i = 0; i < 7; i++) pop();
    pushpop(8'h77, 1'b1);
    chk("pp_mid_cnt", 32'(bus.count), 32'd8);
    drain();
    clr_ovr();

    // level interrupt
    mthr = 4; bus.thresh = 5'd4;
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0);
    push(8'h04, 1'b0);
    pop();
    mthr = 0; bus.thresh = 5'd0;
    step(); check_status();
    push(8'h05, 1'b1); push(8'h06, 1'b0);
    mthr = 17; bus.thresh = 5'd17;
    while (mcount < DEPTH) push(8'h20 + 8'(mcount), 1'b0);
    bus.ovr_clr = 1'b1;
    push(8'hEE, 1'b0);      // drop and clear together: drop wins
    bus.ovr_clr = 1'b0;
    chk("ovr_set_wins", 32'(bus.overrun), 32'd1);
    clr_ovr();
    drain();
    mthr = 0; bus.thresh = 5'd0;

    // push/pop pairs across pointer wrap, then pop on empty
    push(8'h80, 1'b1);
    for (int i = 0; i < 20; i++) pushpop(8'h81 + 8'(i), 1'(i & 1));
    pop();
    pop();

    // flush while holding data
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1'b0);
    bus.rx_en = 1'b0;
    q.delete(); mcount = 0; mov = 1'b0;
    step();
    chk("flush_rd_hold", 32'(bus.rd_data), 32'(last_rd));
    check_status();
    bus.rx_en = 1'b1;
    push(8'h5A, 1'b0);      // writes resume from the reset pointers
    pop();

`ifdef UART_RX_FIFO_TIMEOUT_EN
    push(8'h99, 1'b0);
    for (int i = 0; i < 639; i++) step();
    chk("tout_early", 32'(bus.irq_tout), 32'd0);
    step();
    mtout = 1'b1;
    chk("tout_set", 32'(bus.irq_tout), 32'd1);
    check_status();
    pop();
`else
    push(8'h99, 1'b0);
    for (int i = 0; i < 700; i++) step();
    check_status();
    pop();
`endif

    #10;
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
